// File: rtl/if_fetch_unit_pkg.sv
// Purpose : shared constants for the IF-stage fetch unit (bubble encoding,
//           HALT opcode, fetch FSM state encodings) plus a small helper.
// Ports   : none (package).
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [5:0]  OPC_HALT_DEF  = 6'h3F;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid.sv
// Purpose : one-entry {instr, pc4} holding register that catches an IMEM reply
//           arriving while the downstream stage is stalled.
// Ports   : clk, reset (async active-low), load/clear controls,
//           load_instr/load_pc4 data in, buf_valid/buf_instr/buf_pc4 out.
module if_fetch_unit_skid (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic        buf_valid,
  output logic [31:0] buf_instr,
  output logic [31:0] buf_pc4
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_instr <= 32'h0;
      buf_pc4   <= 32'h0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_instr <= load_instr;
      buf_pc4   <= load_pc4;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Purpose : IF-stage producer. Owns the PC, issues single-outstanding word
//           fetches to IMEM, presents {if_pc_plus_4, if_instruction} to IF_ID,
//           honours stall, squashes wrong-path fetches on redirect and stops
//           after a HALT word is consumed.
// Ports   : clk, reset (async active-low), stall, branch_taken/branch_target,
//           imem_req_valid/ready/addr, imem_rsp_valid/data,
//           if_pc_plus_4, if_instruction, if_halted, if_pc (debug).
//
// state | meaning
// REQ   | no fetch outstanding, may issue
// WAIT  | one fetch outstanding, reply pending
// HALT  | HALT delivered, fetching stopped until reset
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [5:0]  OPC_HALT  = OPC_HALT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_instruction,
  output logic        if_halted,
  output logic [31:0] if_pc
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] inflight_pc4;
  logic        drop;
  logic        halted;

  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;

  logic        rsp_live;
  logic        rsp_keep;
  logic        can_issue;
  logic        accept;
  logic        pres_valid;
  logic        halt_take;
  logic        buf_load;
  logic        buf_clear;

  // Replies only count while a fetch is outstanding; this is what makes a
  // reply left over from before reset invisible.
  assign rsp_live = imem_rsp_valid && (state == ST_WAIT);
  assign rsp_keep = rsp_live && !drop;

  // A reply that lands under stall goes to the skid buffer, so no new fetch
  // may be launched behind it that cycle.
  assign can_issue = ((state == ST_REQ) || rsp_live) && !buf_valid &&
                     !branch_taken && !(rsp_keep && stall);

  assign imem_req_valid = can_issue && reset;
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  always_comb begin
    pres_valid     = 1'b0;
    if_instruction = NOP_INSTR;
    if_pc_plus_4   = 32'h0;
    if (branch_taken) begin
      pres_valid = 1'b0;
    end else if (buf_valid) begin
      pres_valid     = 1'b1;
      if_instruction = buf_instr;
      if_pc_plus_4   = buf_pc4;
    end else if (rsp_keep) begin
      pres_valid     = 1'b1;
      if_instruction = imem_rsp_data;
      if_pc_plus_4   = inflight_pc4;
    end
  end

  assign halt_take = pres_valid && !stall && (if_instruction[31:26] == OPC_HALT);

  assign buf_load  = rsp_keep && stall && !branch_taken && !buf_valid;
  assign buf_clear = branch_taken || !stall;

  if_fetch_unit_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_instr (imem_rsp_data),
    .load_pc4   (inflight_pc4),
    .buf_valid  (buf_valid),
    .buf_instr  (buf_instr),
    .buf_pc4    (buf_pc4)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      inflight_pc4 <= 32'h0;
      drop         <= 1'b0;
      halted       <= 1'b0;
    end else if (state == ST_HALT) begin
      drop <= 1'b0;
    end else if (halt_take) begin
      // Any fetch still in flight is abandoned; HALT ignores replies.
      state  <= ST_HALT;
      halted <= 1'b1;
      drop   <= 1'b0;
    end else begin
      if (branch_taken) begin
        pc <= word_align(branch_target);
      end else if (accept) begin
        pc <= pc + 32'd4;
      end

      if (accept) begin
        inflight_pc4 <= pc + 32'd4;
        state        <= ST_WAIT;
      end else if (rsp_live) begin
        state <= ST_REQ;
      end

      // Redirect with the wrong-path reply still to come: eat it on arrival.
      if (branch_taken && (state == ST_WAIT) && !imem_rsp_valid) begin
        drop <= 1'b1;
      end else if (rsp_live) begin
        drop <= 1'b0;
      end
    end
  end

  assign if_halted = halted;
  assign if_pc     = pc;

  no_skid_overlap: assert property (@(posedge clk) disable iff (!reset)
    !(stall && rsp_live && buf_valid));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_instruction;
  logic        if_halted;
  logic [31:0] if_pc;

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_pc_plus_4   (if_pc_plus_4),
    .if_instruction (if_instruction),
    .if_halted      (if_halted),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  // staged stimulus, applied at the next negedge by cycle()
  logic        n_reset = 1'b0;
  logic        n_stall = 1'b0;
  logic        n_branch = 1'b0;
  logic [31:0] n_target = 32'h0;
  logic        n_ready = 1'b1;

  // IMEM model
  int          lat = 1;
  int          cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_due = 0;
  logic [31:0] halt_addr = 32'hFFFF_FFFF;

  // observations of the current cycle
  logic        o_req;
  logic [31:0] o_addr;
  logic [31:0] o_instr;
  logic [31:0] o_pc4;
  logic        o_halted;
  logic [31:0] o_ifpc;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return 32'hFC00_0000;
    return {6'h08, a[27:2]};
  endfunction

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    reset          = n_reset;
    stall          = n_stall;
    branch_taken   = n_branch;
    branch_target  = n_target;
    imem_req_ready = n_ready;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pend && pend_due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr);
      pend = 1'b0;
    end
    #1;
    o_req    = imem_req_valid;
    o_addr   = imem_addr;
    o_instr  = if_instruction;
    o_pc4    = if_pc_plus_4;
    o_halted = if_halted;
    o_ifpc   = if_pc;
    // scoreboard: every consumed word must be the oldest accepted fetch
    if (reset && !stall && !branch_taken && if_instruction != 32'h0) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got instr %h pc4 %h, required none (cycle %0d)",
                 if_instruction, if_pc_plus_4, cyc);
      end else begin
        e = sb.pop_front();
        if (if_instruction !== e.instr || if_pc_plus_4 !== e.pc4)
          $display("FAIL sb_word: got %h/%h, required %h/%h (cycle %0d)",
                   if_instruction, if_pc_plus_4, e.instr, e.pc4, cyc);
        else n_pass++;
      end
    end
    if (!reset || branch_taken) sb.delete();
    if (reset && imem_req_valid && imem_req_ready) begin
      e.instr = mem_word(imem_addr);
      e.pc4   = imem_addr + 32'd4;
      sb.push_back(e);
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_due  = cyc + lat;
    end
    cyc++;
  endtask

  task automatic do_reset();
    n_reset = 1'b0; n_stall = 1'b0; n_branch = 1'b0; n_ready = 1'b1;
    cycle();
    cycle();
    sb.delete();
    pend = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_reset = 1'b1;
    repeat (3) cycle();
    n_reset = 1'b0;
    cycle();
    n_checks++;
    if (o_req !== 1'b0) $display("FAIL rst_req: got %b required 0", o_req); else n_pass++;
    n_checks++;
    if (o_instr !== 32'h0) $display("FAIL rst_instr: got %h required 0", o_instr); else n_pass++;
    n_checks++;
    if (o_pc4 !== 32'h0) $display("FAIL rst_pc4: got %h required 0", o_pc4); else n_pass++;
    n_checks++;
    if (o_halted !== 1'b0) $display("FAIL rst_halted: got %b required 0", o_halted); else n_pass++;
    n_checks++;
    if (o_ifpc !== 32'h0) $display("FAIL rst_pc: got %h required 0", o_ifpc); else n_pass++;
  endtask

  task automatic test_streaming();
    logic        r[4];
    logic [31:0] a[4];
    logic [31:0] p[4];
    lat = 1;
    do_reset();
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      r[i] = o_req; a[i] = o_addr; p[i] = o_pc4;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r[i] !== 1'b1 || a[i] !== 32'(4 * i))
        $display("FAIL stream_addr%0d: got req %b addr %h, required 1 %h", i, r[i], a[i], 32'(4 * i));
      else n_pass++;
      n_checks++;
      if (p[i+1] !== 32'(4 * (i + 1)))
        $display("FAIL stream_pc4_%0d: got %h required %h", i, p[i+1], 32'(4 * (i + 1)));
      else n_pass++;
    end
  endtask

  task automatic test_stall_skid();
    logic        r[8];
    logic [31:0] a[8];
    logic [31:0] ins[8];
    logic [31:0] p[8];
    lat = 1;
    do_reset();
    n_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_stall = (i >= 3 && i <= 5);
      cycle();
      r[i] = o_req; a[i] = o_addr; ins[i] = o_instr; p[i] = o_pc4;
    end
    n_stall = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      n_checks++;
      if (ins[i] !== mem_word(32'h8) || p[i] !== 32'hC || r[i] !== 1'b0)
        $display("FAIL stall_hold%0d: got %h/%h req %b, required %h/0000000c req 0",
                 i, ins[i], p[i], r[i], mem_word(32'h8));
      else n_pass++;
    end
    n_checks++;
    if (r[7] !== 1'b1 || a[7] !== 32'hC)
      $display("FAIL stall_resume: got req %b addr %h, required 1 0000000c", r[7], a[7]);
    else n_pass++;
  endtask

  task automatic test_redirect();
    logic        r[7];
    logic [31:0] a[7];
    logic [31:0] ins[7];
    logic [31:0] p[7];
    logic [31:0] pc[7];
    lat = 3;
    do_reset();
    n_reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_branch = (i == 1);
      n_target = 32'h0000_0043;
      cycle();
      r[i] = o_req; a[i] = o_addr; ins[i] = o_instr; p[i] = o_pc4; pc[i] = o_ifpc;
    end
    n_branch = 1'b0;
    n_checks++;
    if (ins[1] !== 32'h0 || p[1] !== 32'h0 || r[1] !== 1'b0)
      $display("FAIL br_nop: got %h/%h req %b, required 0/0 req 0", ins[1], p[1], r[1]);
    else n_pass++;
    n_checks++;
    if (pc[2] !== 32'h40) $display("FAIL br_pc: got %h required 00000040", pc[2]); else n_pass++;
    n_checks++;
    if (ins[3] !== 32'h0 || r[3] !== 1'b1 || a[3] !== 32'h40)
      $display("FAIL br_stale: got instr %h req %b addr %h, required 0 1 00000040", ins[3], r[3], a[3]);
    else n_pass++;
    n_checks++;
    if (ins[6] !== mem_word(32'h40) || p[6] !== 32'h44)
      $display("FAIL br_target_word: got %h/%h required %h/00000044", ins[6], p[6], mem_word(32'h40));
    else n_pass++;
    lat = 1;
  endtask

  task automatic test_halt();
    logic [31:0] ins[5];
    logic        h[5];
    logic        r[5];
    int          bad;
    lat = 1;
    halt_addr = 32'h8;
    do_reset();
    n_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      ins[i] = o_instr; h[i] = o_halted; r[i] = o_req;
    end
    n_checks++;
    if (ins[3] !== 32'hFC00_0000 || h[3] !== 1'b0)
      $display("FAIL halt_word: got %h halted %b, required fc000000 0", ins[3], h[3]);
    else n_pass++;
    n_checks++;
    if (h[4] !== 1'b1 || r[4] !== 1'b0)
      $display("FAIL halt_enter: got halted %b req %b, required 1 0", h[4], r[4]);
    else n_pass++;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      n_branch = (j % 3 == 0);
      n_target = 32'h100;
      cycle();
      if (o_req !== 1'b0 || o_instr !== 32'h0 || o_halted !== 1'b1) bad++;
    end
    n_branch = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL halt_hold: got %0d bad cycles, required 0", bad); else n_pass++;
    halt_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset_mid_wait();
    lat = 3;
    do_reset();
    n_reset = 1'b1; n_ready = 1'b1;
    cycle();
    n_reset = 1'b0;
    cycle();
    n_checks++;
    if (o_req !== 1'b0 || o_instr !== 32'h0)
      $display("FAIL rmw_inreset: got req %b instr %h, required 0 0", o_req, o_instr);
    else n_pass++;
    n_reset = 1'b1; n_ready = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (o_instr !== 32'h0 || o_pc4 !== 32'h0 || o_req !== 1'b1 || o_addr !== 32'h0)
      $display("FAIL rmw_stale: got %h/%h req %b addr %h, required 0/0 1 0",
               o_instr, o_pc4, o_req, o_addr);
    else n_pass++;
    n_ready = 1'b1;
    cycle();
    n_checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h0)
      $display("FAIL rmw_first: got req %b addr %h, required 1 0", o_req, o_addr);
    else n_pass++;
    repeat (3) cycle();
    n_checks++;
    if (o_instr !== mem_word(32'h0) || o_pc4 !== 32'h4)
      $display("FAIL rmw_word: got %h/%h required %h/00000004", o_instr, o_pc4, mem_word(32'h0));
    else n_pass++;
    lat = 1;
  endtask

  task automatic test_pc_wrap();
    logic        r[4];
    logic [31:0] a[4];
    logic [31:0] ins[4];
    logic [31:0] p[4];
    logic [31:0] pc[4];
    lat = 1;
    do_reset();
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_branch = (i == 1);
      n_target = 32'hFFFF_FFFF;
      cycle();
      r[i] = o_req; a[i] = o_addr; ins[i] = o_instr; p[i] = o_pc4; pc[i] = o_ifpc;
    end
    n_branch = 1'b0;
    n_checks++;
    if (pc[2] !== 32'hFFFF_FFFC || r[2] !== 1'b1 || a[2] !== 32'hFFFF_FFFC)
      $display("FAIL wrap_issue: got pc %h req %b addr %h, required fffffffc 1 fffffffc", pc[2], r[2], a[2]);
    else n_pass++;
    n_checks++;
    if (ins[3] !== mem_word(32'hFFFF_FFFC) || p[3] !== 32'h0)
      $display("FAIL wrap_pc4: got %h/%h required %h/00000000", ins[3], p[3], mem_word(32'hFFFF_FFFC));
    else n_pass++;
    n_checks++;
    if (r[3] !== 1'b1 || a[3] !== 32'h0)
      $display("FAIL wrap_next: got req %b addr %h, required 1 00000000", r[3], a[3]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_redirect();
    test_halt();
    test_reset_mid_wait();
    test_pc_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
